// File: rtl/alu_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_pkg
// Description : Shared definitions for the bit-serial ALU sequencer: ALU
//               control codes, sequencer state encoding, decoded-control
//               struct and the control decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_serial_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Slice controls plus the bookkeeping bits the sequencer needs at commit.
    typedef struct packed {
        logic       valid;   // recognised control code
        logic       arith;   // carry/overflow flags are meaningful
        logic       slt;     // collapse result to the set bit
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;      // 0 AND, 1 OR, 2 ADD, 3 LESS
        logic       cin;     // carry into bit 0
    } alu_dec_t;

    function automatic alu_dec_t decode_ctrl(input logic [3:0] code);
        alu_dec_t d;
        d = '0;
        case (code)
            ALU_AND: begin
                d.valid = 1'b1;
                d.op    = 2'd0;
            end
            ALU_OR: begin
                d.valid = 1'b1;
                d.op    = 2'd1;
            end
            ALU_ADD: begin
                d.valid = 1'b1;
                d.arith = 1'b1;
                d.op    = 2'd2;
            end
            ALU_SUB: begin
                d.valid = 1'b1;
                d.arith = 1'b1;
                d.b_inv = 1'b1;
                d.op    = 2'd2;
                d.cin   = 1'b1;
            end
            ALU_SLT: begin
                d.valid = 1'b1;
                d.arith = 1'b1;
                d.slt   = 1'b1;
                d.b_inv = 1'b1;
                d.op    = 2'd2;
                d.cin   = 1'b1;
            end
            ALU_NOR: begin
                d.valid = 1'b1;
                d.a_inv = 1'b1;
                d.b_inv = 1'b1;
                d.op    = 2'd0;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_top.sv
`default_nettype none
// ============================================================================
// Module      : alu_top
// Description : 1-bit ALU slice: optional input inversion, AND / OR / full-add
//               / pass-less selection, with carry out.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_top (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic       a_invert_i,
    input  logic       b_invert_i,
    input  logic [1:0] operation_i,
    output logic       result_o,
    output logic       cout_o
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a    = a_i ^ a_invert_i;
    assign w_b    = b_i ^ b_invert_i;
    assign w_sum  = w_a ^ w_b ^ cin_i;
    assign cout_o = (w_a & w_b) | (cin_i & (w_a ^ w_b));

    // Result multiplexer selected by the operation code.
    always_comb begin
        result_o = 1'b0;
        case (operation_i)
            2'd0:    result_o = w_a & w_b;
            2'd1:    result_o = w_a | w_b;
            2'd2:    result_o = w_sum;
            default: result_o = less_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_serial_ctrl
// Description : Bit-serial ALU sequencer. Drives one alu_top slice LSB-first,
//               one bit per clock, closes the carry loop and produces the
//               word result with zero / carry / overflow flags.
//               Optional macro ALU_SERIAL_ABORT_EN adds the abort_i port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [3:0]       ctrl_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
`ifdef ALU_SERIAL_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    import alu_serial_pkg::*;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q,  state_d;
    alu_dec_t         dec_q,    dec_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic w_abort;
    logic w_last;
    logic w_cin;
    logic w_slice_res;
    logic w_slice_cout;
    logic w_ovf;
    logic w_set;

`ifdef ALU_SERIAL_ABORT_EN
    assign w_abort = abort_i;
`else
    assign w_abort = 1'b0;
`endif

    // Bit 0 takes its carry from the decoded control; later bits from the loop.
    assign w_cin  = (idx_q == '0) ? dec_q.cin : carry_q;
    assign w_last = (idx_q == IDX_W'(WIDTH - 1));
    assign w_ovf  = w_cin ^ w_slice_cout;
    assign w_set  = w_slice_res ^ w_ovf;

    alu_top u_slice (
        .a_i         (a_q[idx_q]),
        .b_i         (b_q[idx_q]),
        .cin_i       (w_cin),
        .less_i      (1'b0),
        .a_invert_i  (dec_q.a_inv),
        .b_invert_i  (dec_q.b_inv),
        .operation_i (dec_q.op),
        .result_o    (w_slice_res),
        .cout_o      (w_slice_cout)
    );

    // Sequencer state register and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dec_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dec_q    <= dec_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic: capture in IDLE, one bit per cycle in RUN, commit on last bit.
    always_comb begin
        state_d  = state_q;
        dec_d    = dec_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    dec_d    = decode_ctrl(ctrl_i);
                    a_d      = src1_i;
                    b_d      = src2_i;
                    shadow_d = '0;
                    idx_d    = '0;
                    carry_d  = dec_d.cin;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (w_abort) begin
                    shadow_d = '0;
                    idx_d    = '0;
                    state_d  = IDLE;
                end else begin
                    shadow_d        = shadow_q;
                    shadow_d[idx_q] = w_slice_res;
                    carry_d         = w_slice_cout;
                    idx_d           = idx_q + IDX_W'(1);
                    if (w_last) begin
                        idx_d   = '0;
                        state_d = FINISH;
                        if (!dec_q.valid) begin
                            result_d = '0;
                        end else if (dec_q.slt) begin
                            result_d = {{(WIDTH-1){1'b0}}, w_set};
                        end else begin
                            result_d = shadow_d;
                        end
                        cout_d = dec_q.valid & dec_q.arith & w_slice_cout;
                        ovf_d  = dec_q.valid & dec_q.arith & w_ovf;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready_o    = (state_q == IDLE);
    assign done_o     = (state_q == FINISH);
    assign result_o   = result_q;
    assign zero_o     = (result_q == '0);
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_serial_ctrl
// Description : Directed self-checking bench for alu_serial_ctrl. Abort
//               scenarios are included when ALU_SERIAL_ABORT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

    import alu_serial_pkg::*;

    localparam int W = 32;

    logic         clk_i   = 1'b0;
    logic         rst_n   = 1'b0;
    logic         start_i = 1'b0;
    logic [3:0]   ctrl_i  = 4'b0;
    logic [W-1:0] src1_i  = '0;
    logic [W-1:0] src2_i  = '0;
`ifdef ALU_SERIAL_ABORT_EN
    logic         abort_i = 1'b0;
`endif
    logic         ready_o;
    logic         done_o;
    logic [W-1:0] result_o;
    logic         zero_o;
    logic         cout_o;
    logic         overflow_o;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Bench-side record of the last committed result (for stability checks).
    logic [W-1:0] held = '0;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .ctrl_i     (ctrl_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
`ifdef ALU_SERIAL_ABORT_EN
        .abort_i    (abort_i),
`endif
        .ready_o    (ready_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, " ready"},    ready_o,    1);
        chk({tag, " done"},     done_o,     0);
        chk({tag, " result"},   result_o,   0);
        chk({tag, " zero"},     zero_o,     1);
        chk({tag, " cout"},     cout_o,     0);
        chk({tag, " overflow"}, overflow_o, 0);
    endtask

    // One full operation; poke adds ignored start pulses in RUN and FINISH.
    task automatic do_op(input string tag, input logic [3:0] c,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic ec, input logic eo,
                         input bit poke);
        start_i = 1'b1;
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        step();                                   // E0
        start_i = 1'b0;
        chk({tag, " ready in RUN"}, ready_o, 0);
        if (poke) begin
            start_i = 1'b1;
            ctrl_i  = ALU_ADD;
            src1_i  = 32'h0000_1234;
            src2_i  = 32'h0000_0001;
        end
        for (int k = 1; k < W; k++) begin
            step();
            if (poke && k == 5) start_i = 1'b0;
        end                                       // after E(W-1)
        chk({tag, " no early done"}, done_o, 0);
        chk({tag, " result held"},   result_o, held);
        step();                                   // E(W)
        chk({tag, " done"},     done_o,     1);
        chk({tag, " result"},   result_o,   er);
        chk({tag, " zero"},     zero_o,     (er == '0));
        chk({tag, " cout"},     cout_o,     ec);
        chk({tag, " overflow"}, overflow_o, eo);
        held = er;
        if (poke) start_i = 1'b1;                 // start during FINISH
        step();                                   // E(W+1)
        start_i = 1'b0;
        chk({tag, " done low"}, done_o,  0);
        chk({tag, " ready"},    ready_o, 1);
        if (poke) begin
            step();
            chk({tag, " FINISH start ignored"}, ready_o,  1);
            chk({tag, " result kept"},          result_o, er);
        end
    endtask

    task automatic chk_no_done(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            step();
            seen = seen | done_o;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        // Reset
        repeat (2) step();
        chk_idle_reset("in reset");
        @(negedge clk_i);
        rst_n = 1'b1;
        step();
        chk_idle_reset("after reset");

        do_op("add carry", ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        do_op("sub ovf",   ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        // Reset in the middle of an ADD at idx=10
        start_i = 1'b1;
        ctrl_i  = ALU_ADD;
        src1_i  = 32'h1111_1111;
        src2_i  = 32'h2222_2222;
        step();                                   // E0
        start_i = 1'b0;
        repeat (10) step();                       // idx = 10
        #1 rst_n = 1'b0;
        #1;
        chk_idle_reset("mid-run reset");
        held = '0;
        @(negedge clk_i);
        rst_n = 1'b1;
        chk_no_done("killed op no done", W + 4);

        do_op("and",       ALU_AND, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0FF0_0000, 1'b0, 1'b0, 1'b0);
        do_op("slt neg",   ALU_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        do_op("slt ovf",   ALU_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        do_op("nor poke",  ALU_NOR, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F, 1'b0, 1'b0, 1'b1);
        do_op("or",        ALU_OR,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        do_op("bad code",  4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        do_op("add small", ALU_ADD, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SERIAL_ABORT_EN
        // Abort at idx=20
        start_i = 1'b1;
        ctrl_i  = ALU_ADD;
        src1_i  = 32'd100;
        src2_i  = 32'd200;
        step();                                   // E0
        start_i = 1'b0;
        repeat (20) step();                       // idx = 20
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort ready",  ready_o,  1);
        chk("abort done",   done_o,   0);
        chk("abort result", result_o, 32'h0000_0008);
        chk("abort zero",   zero_o,   0);
        chk_no_done("abort no done", W + 4);

        // Abort coinciding with the commit edge
        start_i = 1'b1;
        ctrl_i  = ALU_SUB;
        src1_i  = 32'd1;
        src2_i  = 32'd2;
        step();                                   // E0
        start_i = 1'b0;
        repeat (W - 1) step();                    // idx = W-1
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        chk("abort@commit ready",  ready_o,    1);
        chk("abort@commit done",   done_o,     0);
        chk("abort@commit result", result_o,   32'h0000_0008);
        chk("abort@commit cout",   cout_o,     0);
        chk("abort@commit ovf",    overflow_o, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_serial_ctrl.md
# alu_serial_ctrl

Bit-serial 32-bit ALU sequencer that sits directly upstream of the 1-bit ALU slice `alu_top` and consumes its outputs. It decodes a 4-bit ALU control code and drives one slice instance LSB-first, one bit per clock. It closes the carry loop (`cout` → next `cin`), assembles the word result and produces zero, carry and overflow flags. It gives the control path a single-slice, area-minimal alternative to the 32-slice ripple ALU, using a start/done handshake.

## Interface
- `WIDTH`, 32, operand/result width; legal range 2..64.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  request; accepted only while `ready_o`=1.
- `ctrl_i`  in  4  ALU control, sampled with `start_i`.
- `src1_i`, `src2_i`  in  WIDTH  operands, sampled with `start_i`.
- `ready_o`  out  1  idle and able to accept `start_i`.
- `done_o`  out  1  one-cycle pulse; the result and flags are valid in this cycle.
- `result_o`  out  WIDTH  last completed result, held until the next completion.
- `zero_o`  out  1  `result_o` == 0.
- `cout_o`  out  1  carry out of the MSB for ADD, SUB and SLT; 0 otherwise.
- `overflow_o`  out  1  signed overflow for ADD, SUB and SLT; 0 otherwise.
- `abort_i`  in  1  present only with `ALU_SERIAL_ABORT_EN`.

## Operation
- Control decode (slice inputs A_invert / B_invert / operation / initial cin):
  - AND 0000 → 0/0/0/0
  - OR 0001 → 0/0/1/0
  - ADD 0010 → 0/0/2/0
  - SUB 0110 → 0/1/2/1
  - SLT 0111 → 0/1/2/1
  - NOR 1100 → 1/1/0/0
- Any other code: result 0, `cout_o`=0, `overflow_o`=0; timing is unchanged.
- Slice `less` input is tied 0.
- States:
  - IDLE: `ready_o`=1. `start_i`=1 captures the operands and decoded controls, clears the bit index, loads the initial cin, and goes to RUN.
  - RUN: the slice sees operand bit[idx]. Each edge shifts the slice result into the shadow register, sets carry ← slice `cout`, and increments idx.
    - On the edge with idx=WIDTH-1, commit the shadow register plus the final bit to `result_o`.
    - `cout_o` ← MSB `cout`.
    - `overflow_o` ← MSB cin ^ MSB `cout`.
    - Then go to FINISH.
  - FINISH: `done_o`=1 for exactly one cycle, then unconditionally go to IDLE.
- SLT: RUN performs the subtract. At commit, `result_o` ← {0…0, set}, where set = MSB sum ^ overflow. `cout_o` and `overflow_o` report the subtract.
- `start_i` outside IDLE (including FINISH) is ignored; operands are not re-sampled.
- `zero_o` is derived combinationally from the registered `result_o`.

## Timing
- Reset values: state IDLE, `ready_o`=1, `done_o`=0, `result_o`=0, `zero_o`=1, `cout_o`=0, `overflow_o`=0, idx=0.
- Latency: start accepted at edge E0. RUN spans WIDTH cycles; `done_o` goes high after edge E(WIDTH) and is low again after E(WIDTH+1).
- Throughput: one operation per WIDTH+2 cycles (IDLE → RUN → FINISH → IDLE).
- `result_o` and the flags change only on the commit edge and are stable otherwise.
- Reset asserted mid-RUN or mid-FINISH forces all reset values immediately. No `done_o` is produced for the killed operation.

## Configuration
- `ALU_SERIAL_ABORT_EN` defined: `abort_i` port exists.
  - `abort_i`=1 in RUN → IDLE on the next edge; no `done_o`. `result_o` and the flags keep their previous values, and the shadow register is discarded.
  - `abort_i` is ignored in IDLE and FINISH.
  - `abort_i` wins over the commit edge when both coincide.
- Not defined: no `abort_i` port; every accepted start completes.

## Structure
- Shared package `alu_serial_pkg` holds:
  - control code constants (`ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_SUB`, `ALU_SLT`, `ALU_NOR`);
  - the state enum typedef (IDLE/RUN/FINISH);
  - the decoded-control struct typedef.
- One sub-module: the existing `alu_top` slice, instantiated once; all sequencing stays in `alu_serial_ctrl`.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001 → `result_o`=0, `zero_o`=1, `cout_o`=1, `overflow_o`=0, `done_o` after edge E32.
- SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, `overflow_o`=1, `cout_o`=1, `zero_o`=0.
- SLT 0xFFFFFFFF vs 0x00000001 → 1; SLT 0x7FFFFFFF vs 0x80000000 → 0 (overflow path).
- NOR 0xF0F0F0F0, 0x0F0F0000 → 0x0000F0F... expected 0x00000F0F. Pulse `start_i` with new operands during RUN → ignored; `result_o` still 0x00000F0F.
- Reset (`rst_n`=0) at idx=10 of an ADD → all outputs at reset values immediately. A fresh AND 0xFFFF0000 & 0x0FF00FF0 then gives 0x0FF00000.
- With `ALU_SERIAL_ABORT_EN`: ADD 5+3 → 8; next ADD aborted at idx=20 → no `done_o`, `result_o` stays 8, `ready_o`=1 next cycle.
